pipelined_barrel_shifter: RTL and testbench

// - Parametrised, optionally pipelined log-stage barrel shifter for the ALU shift path.
// - Supports SLL, SRL, SRA and ROR on a WIDTH-bit operand; the shift amount is SHAMT_W bits.
// - Any stage boundary can be registered, so the shift path can be retimed without changing the ALU.
// - Valid/ready handshake on input and output; the whole pipeline stalls on backpressure.

---
 rtl/pipelined_barrel_shifter.sv | 122 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Log-stage barrel shifter (SLL/SRL/SRA/ROR) with a configurable set of
// registered stage boundaries and a single global valid/ready advance.
// Stage k shifts by 2^k when shamt[k] is set; stages run from the MSB
// of shamt down to bit 0. REG_MASK bit k places a register after stage k.

module pipelined_barrel_shifter #(
  parameter int                 WIDTH    = 32,
  parameter int                 SHAMT_W  = $clog2(WIDTH),
  parameter logic [SHAMT_W-1:0] REG_MASK = SHAMT_W'(5'b10100)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic int popcount(input logic [SHAMT_W-1:0] m);
    int n;
    n = 0;
    for (int b = 0; b < SHAMT_W; b++) begin
      if (m[b]) n++;
    end
    return n;
  endfunction

  // Input-to-output latency in cycles (number of registered boundaries).
  localparam int LAT = popcount(REG_MASK);

  // Everything a beat needs to finish its shift downstream: the sign bit is
  // the original operand MSB so later SRA stages fill correctly.
  typedef struct packed {
    logic               valid;
    logic               sign;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
  } beat_t;

  beat_t head;
  beat_t tail;
  logic  adv;
  logic  unused_tail;

  // A beat presented while reset is high is never launched.
  assign head = '{valid: in_valid & ~reset,
                  sign:  in_data[WIDTH-1],
                  op:    in_op,
                  shamt: in_shamt,
                  data:  in_data};

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int K   = SHAMT_W - 1 - i;
    localparam int AMT = 1 << K;

    beat_t cur;
    beat_t nxt;
    beat_t dn;

    if (i == 0) begin : g_first
      assign cur = head;
    end else begin : g_link
      assign cur = g_stage[i-1].dn;
    end

    // Conditional shift by 2^K; fill depends on the op carried with the beat.
    always_comb begin
      nxt = cur;
      if (cur.shamt[K]) begin
        unique case (cur.op)
          OP_SLL: nxt.data = cur.data << AMT;
          OP_SRL: nxt.data = cur.data >> AMT;
          OP_SRA: nxt.data = (cur.data >> AMT)
                             | (cur.sign ? ~({WIDTH{1'b1}} >> AMT) : {WIDTH{1'b0}});
          OP_ROR: nxt.data = (cur.data >> AMT) | (cur.data << (WIDTH - AMT));
        endcase
      end
    end

    if (REG_MASK[K]) begin : g_reg
      beat_t q;

      // Boundary register: loads on every advance (bubbles included), holds on stall.
      always_ff @(posedge clock) begin
        if (reset) begin
          q <= '0;
        end else if (adv) begin
          q <= nxt;
        end
      end

      assign dn = q;
    end else begin : g_wire
      assign dn = nxt;
    end
  end

  assign tail      = g_stage[SHAMT_W-1].dn;
  assign out_valid = tail.valid;
  assign out_data  = tail.data;

  // Only valid and data leave the block; the rest of the beat ends here.
  assign unused_tail = ^{tail.sign, tail.op, tail.shamt};

  // Whole pipeline moves together unless a finished result is stuck.
  assign adv = ~out_valid | out_ready;

  // Fully combinational build has no storage to absorb a beat, so it simply
  // mirrors the consumer. Reset always reads as ready since it flushes anyway.
  assign in_ready = reset | ((LAT == 0) ? out_ready : adv);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: default build (latency 2),
// fully combinational build and fully registered build (latency 5).

module tb_pipelined_barrel_shifter;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;

  logic rdy_m, vld_m, rdy_c, vld_c, rdy_f, vld_f;
  logic [W-1:0] dat_m, dat_c, dat_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(vld_m), .out_ready(out_ready), .out_data(dat_m));

  pipelined_barrel_shifter #(.WIDTH(W), .REG_MASK(5'b00000)) dut_comb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(vld_c), .out_ready(out_ready), .out_data(dat_c));

  pipelined_barrel_shifter #(.WIDTH(W), .REG_MASK(5'b11111)) dut_full (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_f),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(vld_f), .out_ready(out_ready), .out_data(dat_f));

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    int sh;
    sh = int'(s);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return 32'($signed(d) >>> sh);
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] s,
                       input logic [31:0] d);
    in_valid = v;
    in_op    = op;
    in_shamt = s;
    in_data  = d;
  endtask

  // One isolated beat, observed on all three builds.
  task automatic run_vec(input int idx);
    int lat_m, lat_f;
    logic [31:0] d_m, d_f;
    string tag;
    lat_m = -1; lat_f = -1; d_m = '0; d_f = '0;
    tag = $sformatf("vec%0d", idx);
    @(posedge clock); #1;
    out_ready = 1'b1;
    drive(1'b1, vecs[idx].op, vecs[idx].shamt, vecs[idx].data);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check({tag, "_comb_valid"}, 32'(vld_c), 32'd1);
        check({tag, "_comb_data"}, dat_c, vecs[idx].exp);
      end
      if (vld_m && lat_m < 0) begin lat_m = c; d_m = dat_m; end
      if (vld_f && lat_f < 0) begin lat_f = c; d_f = dat_f; end
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
    check({tag, "_lat"}, 32'(lat_m), 32'd2);
    check({tag, "_data"}, d_m, vecs[idx].exp);
    check({tag, "_full_lat"}, 32'(lat_f), 32'd5);
    check({tag, "_full_data"}, d_f, vecs[idx].exp);
  endtask

  // Handshaked stream of n beats into the default build with an optional
  // window of cycles where the consumer refuses results.
  task automatic run_stream(input string tag, input int n, input int stall_lo,
                            input int stall_hi, input int exp_first);
    logic [31:0] bd[8];
    logic [31:0] be[8];
    logic [4:0]  bs[8];
    logic [1:0]  bo[8];
    int idx, oidx, first, last;
    logic prev_stall;
    logic [31:0] prev_data;
    for (int i = 0; i < n; i++) begin
      bd[i] = 32'h9E37_79B9 * 32'(i + 1);
      bs[i] = 5'(i * 5 + 3);
      bo[i] = 2'(i);
      be[i] = model(bd[i], bs[i], bo[i]);
    end
    idx = 0; oidx = 0; first = -1; last = -1;
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock); #1;
      out_ready = !(c >= stall_lo && c <= stall_hi);
      if (idx < n) drive(1'b1, bo[idx], bs[idx], bd[idx]);
      else         in_valid = 1'b0;
      @(negedge clock);
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 32'(vld_m), 32'd1);
        check({tag, "_hold_data"}, dat_m, prev_data);
      end
      check({tag, "_in_ready"}, 32'(rdy_m), 32'(!(vld_m && !out_ready)));
      if (in_valid && rdy_m) idx++;
      if (vld_m && out_ready) begin
        if (oidx < n) begin
          check($sformatf("%s_data%0d", tag, oidx), dat_m, be[oidx]);
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL %s_extra: got beat %0d expected only %0d", tag, oidx, n);
        end
        if (first < 0) first = c;
        last = c;
        oidx++;
      end
      prev_stall = vld_m && !out_ready;
      prev_data  = dat_m;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(oidx), 32'(n));
    check({tag, "_first"}, 32'(first), 32'(exp_first));
    check({tag, "_span"}, 32'(last - first), 32'(n - 1));
  endtask

  // Reset with beats in flight, then one clean beat.
  task automatic run_reset_midflight();
    int cnt, first;
    logic [31:0] d;
    @(posedge clock); #1;
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd4, 32'hF000_0000);
    @(posedge clock); #1;
    drive(1'b1, 2'b00, 5'd1, 32'h0000_0001);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd4, 32'h0000_0001);
    @(negedge clock);
    check("rst_in_ready", 32'(rdy_m), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 32'(vld_m), 32'd0);
    check("rst_out_data", dat_m, 32'd0);
    check("rst_full_valid", 32'(vld_f), 32'd0);
    cnt = 0; first = -1; d = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (c == 0) drive(1'b1, 2'b10, 5'd4, 32'h8000_0010);
      else        in_valid = 1'b0;
      @(negedge clock);
      if (vld_m) begin
        cnt++;
        if (first < 0) begin first = c; d = dat_m; end
      end
    end
    check("rst_post_count", 32'(cnt), 32'd1);
    check("rst_post_lat", 32'(first), 32'd2);
    check("rst_post_data", d, 32'hF800_0001);
  endtask

  // Random ops/amounts with bubbles against the reference model on all builds.
  task automatic run_random();
    localparam int NR = 40;
    logic        rv[NR];
    logic [31:0] rd[NR];
    logic [31:0] re[NR];
    logic [4:0]  rs[NR];
    logic [1:0]  ro[NR];
    for (int i = 0; i < NR; i++) begin
      rv[i] = ($urandom_range(0, 3) != 0);
      rd[i] = $urandom;
      rs[i] = 5'($urandom_range(0, 31));
      ro[i] = 2'($urandom_range(0, 3));
      re[i] = model(rd[i], rs[i], ro[i]);
    end
    for (int c = 0; c < NR + 6; c++) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      if (c < NR) drive(rv[c], ro[c], rs[c], rd[c]);
      else        in_valid = 1'b0;
      @(negedge clock);
      if (c < NR) begin
        check($sformatf("rnd_comb_valid%0d", c), 32'(vld_c), 32'(rv[c]));
        if (rv[c]) check($sformatf("rnd_comb_data%0d", c), dat_c, re[c]);
      end
      if (c >= 2 && c - 2 < NR) begin
        check($sformatf("rnd_valid%0d", c - 2), 32'(vld_m), 32'(rv[c-2]));
        if (rv[c-2]) check($sformatf("rnd_data%0d", c - 2), dat_m, re[c-2]);
      end
      if (c >= 5 && c - 5 < NR) begin
        check($sformatf("rnd_full_valid%0d", c - 5), 32'(vld_f), 32'(rv[c-5]));
        if (rv[c-5]) check($sformatf("rnd_full_data%0d", c - 5), dat_f, re[c-5]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F};
    vecs[1]  = '{2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F};
    vecs[2]  = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[3]  = '{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000};
    vecs[4]  = '{2'b00, 5'd0,  32'h8000_00F0, 32'h8000_00F0};
    vecs[5]  = '{2'b01, 5'd0,  32'h8000_00F0, 32'h8000_00F0};
    vecs[6]  = '{2'b10, 5'd0,  32'h8000_00F0, 32'h8000_00F0};
    vecs[7]  = '{2'b11, 5'd0,  32'h8000_00F0, 32'h8000_00F0};
    vecs[8]  = '{2'b00, 5'd4,  32'h1234_5678, 32'h2345_6780};
    vecs[9]  = '{2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456};
    vecs[10] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[11] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[13] = '{2'b11, 5'd31, 32'h8000_0001, 32'h0000_0003};
    vecs[14] = '{2'b00, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_0000};
    vecs[15] = '{2'b11, 5'd4,  32'hF000_000F, 32'hFF00_0000};

    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", 32'(rdy_m), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_out_valid", 32'(vld_m), 32'd0);
    check("reset_out_data", dat_m, 32'd0);
    check("reset_full_valid", 32'(vld_f), 32'd0);
    check("reset_full_data", dat_f, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(i);

    run_stream("stream", 8, 1, 0, 2);
    run_stream("stall", 4, 2, 4, 5);

    run_reset_midflight();

    repeat (8) @(posedge clock);
    run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
